// File: rtl/cpu_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the model-CPU sequencer:
//   - seq_state_t : sequencer state encoding (IDLE..PAUSE, fixed values)
//   - default widths / timeout for the retired-instruction counter and the
//     IO wait timer
//   - ack_match   : true when the acknowledge matching the active request is
//                   present
// ----------------------------------------------------------------------------
package cpu_seq_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int IO_TIMEOUT_DEF = 255;
    localparam int TMR_W_DEF      = 8;

    // Encodings are fixed so that state values seen in waveforms or by other
    // tools stay stable across builds. PAUSE exists in the type even when
    // single-step support is compiled out.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        IO_WAIT = 3'd3,
        IO_DONE = 3'd4,
        HALTED  = 3'd5,
        PAUSE   = 3'd6
    } seq_state_t;

    // Only the acknowledge belonging to the outstanding request completes a
    // transfer; a stray ack of the other kind is ignored.
    function automatic logic ack_match(input logic in_req, input logic out_req,
                                       input logic in_ack, input logic out_ack);
        return (in_req & in_ack) | (out_req & out_ack);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// cpu_sequencer_if
// Bundle of the decoder / peripheral-facing signals of the sequencer.
//   Decoder -> sequencer : run, halt, in1, out1
//   Peripheral -> seq.   : in_ack, out_ack
//   Sequencer -> others  : sm, stall, in_req, out_req, halted, io_err,
//                          instr_cnt[CNT_W-1:0]
// Modports:
//   master : the sequencer side (drives sm/stall/requests/status)
//   slave  : the decoder + peripheral side
// ----------------------------------------------------------------------------
interface cpu_sequencer_if #(
    parameter int CNT_W = cpu_seq_pkg::CNT_W_DEF
);
    logic             run;
    logic             halt;
    logic             in1;
    logic             out1;
    logic             in_ack;
    logic             out_ack;
    logic             sm;
    logic             stall;
    logic             in_req;
    logic             out_req;
    logic             halted;
    logic             io_err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, halt, in1, out1, in_ack, out_ack,
        output sm, stall, in_req, out_req, halted, io_err, instr_cnt
    );

    modport slave (
        output run, halt, in1, out1, in_ack, out_ack,
        input  sm, stall, in_req, out_req, halted, io_err, instr_cnt
    );
endinterface

// File: rtl/cpu_sequencer_io_wait_timer.sv
// ----------------------------------------------------------------------------
// io_wait_timer
// Counts cycles spent waiting for a peripheral acknowledge.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  synchronous reset, active-low
//   clear   in  force the count to zero (takes precedence over enable)
//   enable  in  advance the count by one
//   expired out count has reached IO_TIMEOUT-1 (never set when IO_TIMEOUT=0)
// ----------------------------------------------------------------------------
module io_wait_timer
    import cpu_seq_pkg::*;
#(
    parameter int IO_TIMEOUT = IO_TIMEOUT_DEF,
    parameter int TMR_W      = TMR_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Last count value before the transfer is forced to complete. With the
    // timeout disabled the comparison is masked off below, so the value is
    // irrelevant.
    localparam logic [TMR_W-1:0] LAST = (IO_TIMEOUT == 0) ? '0 : TMR_W'(IO_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = (IO_TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Fetch/execute timing controller for the 8-bit model CPU. Produces the phase
// bit sm (0 fetch, 1 execute), owns the halt state and the IN/OUT peripheral
// handshakes, stalls the datapath during transfers and counts retired
// instructions.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active-low
//   step   in   single-step advance (only with SINGLE_STEP_EN defined)
//   bus    master modport of cpu_sequencer_if:
//            run, halt, in1, out1, in_ack, out_ack  (inputs)
//            sm, stall, in_req, out_req, halted, io_err, instr_cnt (outputs)
//
// Configuration macro:
//   SINGLE_STEP_EN - adds the step input and a PAUSE state entered after every
//                    retire; a rising edge on step resumes with the next fetch.
// ----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int IO_TIMEOUT = IO_TIMEOUT_DEF,
    parameter int TMR_W      = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    cpu_sequencer_if.master  bus
);

`ifdef SINGLE_STEP_EN
    localparam seq_state_t RETIRE_TO = PAUSE;
`else
    localparam seq_state_t RETIRE_TO = FETCH;
`endif

    seq_state_t       state;
    logic             sm_q;
    logic             in_req_q;
    logic             out_req_q;
    logic             halted_q;
    logic             io_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall_c;
    logic             ack_hit;
    logic             timer_expired;
`ifdef SINGLE_STEP_EN
    logic             step_q;
`endif

    // The timer is held at zero outside IO_WAIT, so every transfer starts
    // counting from zero on its first wait cycle.
    io_wait_timer #(
        .IO_TIMEOUT(IO_TIMEOUT),
        .TMR_W     (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != IO_WAIT),
        .enable (state == IO_WAIT),
        .expired(timer_expired)
    );

    assign ack_hit = ack_match(in_req_q, out_req_q, bus.in_ack, bus.out_ack);

    // Sequencer state machine. All outputs except stall are registered and
    // updated on the same edge as the transition that changes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sm_q      <= 1'b0;
            in_req_q  <= 1'b0;
            out_req_q <= 1'b0;
            halted_q  <= 1'b0;
            io_err_q  <= 1'b0;
            cnt_q     <= '0;
`ifdef SINGLE_STEP_EN
            step_q    <= 1'b0;
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            step_q <= step;
`endif
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= EXEC;
                    sm_q  <= 1'b1;
                end
                EXEC: begin
                    // HALT outranks IN, which outranks OUT; both IN and OUT
                    // together is a decoder error and is treated as IN.
                    if (bus.halt) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else if (bus.in1) begin
                        state    <= IO_WAIT;
                        in_req_q <= 1'b1;
                    end else if (bus.out1) begin
                        state     <= IO_WAIT;
                        out_req_q <= 1'b1;
                    end else begin
                        state <= RETIRE_TO;
                        sm_q  <= 1'b0;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IO_WAIT: begin
                    // An ack arriving on the timeout cycle still counts as a
                    // clean completion.
                    if (ack_hit || timer_expired) begin
                        state     <= IO_DONE;
                        in_req_q  <= 1'b0;
                        out_req_q <= 1'b0;
                        if (!ack_hit) begin
                            io_err_q <= 1'b1;
                        end
                    end
                end
                IO_DONE: begin
                    state <= RETIRE_TO;
                    sm_q  <= 1'b0;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                HALTED: begin
                    state <= HALTED;
                end
`ifdef SINGLE_STEP_EN
                PAUSE: begin
                    if (step && !step_q) begin
                        state <= FETCH;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    sm_q      <= 1'b0;
                    in_req_q  <= 1'b0;
                    out_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall must cover the EXEC cycle of an IO instruction, before the
    // request register has risen, so it looks at the decoder inputs directly.
    always_comb begin
        stall_c = 1'b0;
        case (state)
            EXEC:    stall_c = (bus.in1 | bus.out1) & ~bus.halt;
            IO_WAIT: stall_c = 1'b1;
            HALTED:  stall_c = 1'b1;
`ifdef SINGLE_STEP_EN
            PAUSE:   stall_c = 1'b1;
`endif
            default: stall_c = 1'b0;
        endcase
    end

    assign bus.sm        = sm_q;
    assign bus.stall     = stall_c;
    assign bus.in_req    = in_req_q;
    assign bus.out_req   = out_req_q;
    assign bus.halted    = halted_q;
    assign bus.io_err    = io_err_q;
    assign bus.instr_cnt = cnt_q;

endmodule
